snd_rom_arbiter: RTL

//  Shares one 16-bit external sound-ROM port (SDRAM/BRAM bridge) between the four audio ROM readers:
//  Z80 program ROM, theme ROM, 007232 PCM ROM and uPD7759 ROM. Each requester posts a read and

---
 rtl/snd_rom_pkg.sv | 39 +++
 rtl/snd_rom_arbiter_if.sv | 26 ++
 rtl/snd_rom_req_slot.sv | 102 ++++++++++
 rtl/snd_rom_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/snd_rom_pkg.sv
// Shared constants for the sound-ROM arbiter: requester indices,
// FSM states, default region bases and the round-robin picker.
package snd_rom_pkg;

  localparam int MEM_AW_DEF = 24;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_Z80   = 2'd0;
  localparam req_idx_t REQ_THEME = 2'd1;
  localparam req_idx_t REQ_K7232 = 2'd2;
  localparam req_idx_t REQ_UPD   = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } arb_st_t;

  localparam logic [23:0] Z80_BASE_DEF   = 24'h000000;
  localparam logic [23:0] THEME_BASE_DEF = 24'h004000;
  localparam logic [23:0] K7232_BASE_DEF = 24'h044000;
  localparam logic [23:0] UPD_BASE_DEF   = 24'h054000;

  // {found, index} of first pending bit at or after ptr
  function automatic logic [2:0] rr_pick(
    input logic [3:0] p,
    input req_idx_t   ptr
  );
    logic [2:0] r;
    req_idx_t   i;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      i = ptr + 2'(k);
      if (p[i]) r = {1'b1, i};
    end
    return r;
  endfunction

endpackage

// File: rtl/snd_rom_arbiter_if.sv
// External sound-ROM read port: request/address out,
// single-cycle ack with data back.
interface snd_rom_arbiter_if
  import snd_rom_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
);
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_din;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_din
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_din
  );
endinterface

// File: rtl/snd_rom_req_slot.sv
// One requester slot: address latch, pending/rdy, held data,
// byte select; optional hit cache under SNDROM_HITCACHE_EN.
module snd_rom_req_slot #(
  parameter int              AW     = 15,
  parameter int              DW     = 8,
  parameter int              MEM_AW = 24,
  parameter bit              WIDE   = 1'b0,
  parameter logic [MEM_AW-1:0] BASE = '0
) (
  input  logic              clk_main,
  input  logic              RESET,
  input  logic              rd,
  input  logic [AW-1:0]     addr,
  input  logic              grant,
  input  logic              ack,
  input  logic [15:0]       din,
  output logic              pending,
  output logic [MEM_AW-1:0] waddr,
  output logic              rdy,
  output logic [DW-1:0]     dout
);

  function automatic logic [MEM_AW-1:0] wmap(input logic [AW-1:0] a);
    return WIDE ? BASE + MEM_AW'(a) : BASE + MEM_AW'(a >> 1);
  endfunction

  function automatic logic [DW-1:0] bsel(input logic [15:0] w, input logic b);
    return DW'((WIDE || !b) ? w : {8'h00, w[15:8]});
  endfunction

  logic [AW-1:0] addr_q;
  logic          sel_q;
  logic          busy_q;
  logic          again_q;
  logic          hit;
  logic [15:0]   hit_word;

  assign waddr = wmap(addr_q);

`ifdef SNDROM_HITCACHE_EN
  logic [MEM_AW-1:0] tag_q;
  logic [MEM_AW-1:0] ftag_q;
  logic [15:0]       cdat_q;
  logic              cval_q;

  assign hit      = cval_q && !pending && (tag_q == wmap(addr));
  assign hit_word = cdat_q;

  always_ff @(posedge clk_main) begin
    if (RESET) begin
      tag_q  <= '0;
      ftag_q <= '0;
      cdat_q <= '0;
      cval_q <= 1'b0;
    end else begin
      if (grant) ftag_q <= waddr;
      if (ack) begin
        tag_q  <= ftag_q;
        cdat_q <= din;
        cval_q <= 1'b1;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = 16'h0000;
`endif

  always_ff @(posedge clk_main) begin
    if (RESET) begin
      addr_q  <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      again_q <= 1'b0;
      pending <= 1'b0;
      rdy     <= 1'b1;
      dout    <= '0;
    end else begin
      if (grant) begin
        busy_q <= 1'b1;
        sel_q  <= addr_q[0];
      end
      if (ack) begin
        dout    <= bsel(din, sel_q);
        busy_q  <= 1'b0;
        again_q <= 1'b0;
        pending <= rd || again_q;
        rdy     <= !(rd || again_q);
        if (rd) addr_q <= addr;
      end else if (rd && hit) begin
        dout <= bsel(hit_word, addr[0]);
      end else if (rd) begin
        addr_q  <= addr;
        pending <= 1'b1;
        rdy     <= 1'b0;
        // a read landing on an in-flight access needs its own access later
        if (busy_q || grant) again_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/snd_rom_arbiter.sv
// Round-robin arbiter sharing one 16-bit sound-ROM port among
// Z80, theme, 007232 and uPD7759 readers. Option: SNDROM_HITCACHE_EN.
module snd_rom_arbiter
  import snd_rom_pkg::*;
#(
  parameter int                MEM_AW     = 24,
  parameter logic [MEM_AW-1:0] Z80_BASE   = Z80_BASE_DEF,
  parameter logic [MEM_AW-1:0] THEME_BASE = THEME_BASE_DEF,
  parameter logic [MEM_AW-1:0] K7232_BASE = K7232_BASE_DEF,
  parameter logic [MEM_AW-1:0] UPD_BASE   = UPD_BASE_DEF
) (
  input  logic          clk_main,
  input  logic          RESET,
  input  logic [14:0]   z80_addr,
  input  logic          z80_rd,
  output logic [7:0]    z80_dout,
  output logic          z80_rdy,
  input  logic [17:0]   theme_addr,
  input  logic          theme_rd,
  output logic [15:0]   theme_dout,
  output logic          theme_rdy,
  input  logic [16:0]   k7232_addr,
  input  logic          k7232_rd,
  output logic [7:0]    k7232_dout,
  output logic          k7232_rdy,
  input  logic [16:0]   upd_addr,
  input  logic          upd_rd,
  output logic [7:0]    upd_dout,
  output logic          upd_rdy,
  snd_rom_arbiter_if.master mem
);

  arb_st_t           st_q;
  req_idx_t          ptr_q;
  req_idx_t          gidx_q;
  logic [3:0]        pend;
  logic [3:0]        gnt_v;
  logic [3:0]        ack_v;
  logic [2:0]        pk;
  logic [MEM_AW-1:0] wa [4];

  always_comb begin
    pk    = rr_pick(pend, ptr_q);
    gnt_v = '0;
    ack_v = '0;
    if (st_q == ST_IDLE && pk[2]) gnt_v[pk[1:0]] = 1'b1;
    if (st_q == ST_BUSY && mem.mem_ack) ack_v[gidx_q] = 1'b1;
  end

  always_ff @(posedge clk_main) begin
    if (RESET) begin
      st_q         <= ST_IDLE;
      ptr_q        <= REQ_Z80;
      gidx_q       <= REQ_Z80;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (pk[2]) begin
            gidx_q       <= pk[1:0];
            ptr_q        <= pk[1:0] + 2'd1;
            mem.mem_addr <= wa[pk[1:0]];
            mem.mem_req  <= 1'b1;
            st_q         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            st_q        <= ST_IDLE;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  snd_rom_req_slot #(
    .AW(15), .DW(8), .MEM_AW(MEM_AW), .WIDE(1'b0), .BASE(Z80_BASE)
  ) u_z80 (
    .clk_main(clk_main), .RESET(RESET),
    .rd(z80_rd), .addr(z80_addr),
    .grant(gnt_v[REQ_Z80]), .ack(ack_v[REQ_Z80]), .din(mem.mem_din),
    .pending(pend[REQ_Z80]), .waddr(wa[REQ_Z80]),
    .rdy(z80_rdy), .dout(z80_dout)
  );

  snd_rom_req_slot #(
    .AW(18), .DW(16), .MEM_AW(MEM_AW), .WIDE(1'b1), .BASE(THEME_BASE)
  ) u_theme (
    .clk_main(clk_main), .RESET(RESET),
    .rd(theme_rd), .addr(theme_addr),
    .grant(gnt_v[REQ_THEME]), .ack(ack_v[REQ_THEME]), .din(mem.mem_din),
    .pending(pend[REQ_THEME]), .waddr(wa[REQ_THEME]),
    .rdy(theme_rdy), .dout(theme_dout)
  );

  snd_rom_req_slot #(
    .AW(17), .DW(8), .MEM_AW(MEM_AW), .WIDE(1'b0), .BASE(K7232_BASE)
  ) u_k7232 (
    .clk_main(clk_main), .RESET(RESET),
    .rd(k7232_rd), .addr(k7232_addr),
    .grant(gnt_v[REQ_K7232]), .ack(ack_v[REQ_K7232]), .din(mem.mem_din),
    .pending(pend[REQ_K7232]), .waddr(wa[REQ_K7232]),
    .rdy(k7232_rdy), .dout(k7232_dout)
  );

  snd_rom_req_slot #(
    .AW(17), .DW(8), .MEM_AW(MEM_AW), .WIDE(1'b0), .BASE(UPD_BASE)
  ) u_upd (
    .clk_main(clk_main), .RESET(RESET),
    .rd(upd_rd), .addr(upd_addr),
    .grant(gnt_v[REQ_UPD]), .ack(ack_v[REQ_UPD]), .din(mem.mem_din),
    .pending(pend[REQ_UPD]), .waddr(wa[REQ_UPD]),
    .rdy(upd_rdy), .dout(upd_dout)
  );

endmodule
